instr_prefetch_queue: RTL and testbench

- Decoupled instruction-fetch front end that sits directly upstream of the decode stage, in place of the single-cycle fetch path.
- Issues sequential PC requests to a latency-variable instruction memory over a valid/ready interface.
- Buffers returned instructions with their PCs in an in-order FIFO and hands them to decode over a valid/ready interface.
- On a taken branch or jump resolved in execute, flushes the buffer, discards in-flight responses and restarts fetch at the target.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 55 +++++
 rtl/instr_prefetch_queue.sv | 121 ++++++++++++
 tb/tb_instr_prefetch_queue.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch front end.
package fetch_pkg;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] INSTR_NOP   = 32'h00000013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int ENTRY_W = $bits(fetch_entry_t);

    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, flush, and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= next_ptr(wr_ptr_reg);
            if (do_pop)  rd_ptr_reg <= next_ptr(rd_ptr_reg);
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Decoupled fetch front end: sequential imem requests, in-order buffering, redirect flush.
// Define PREFETCH_BYPASS_EN to forward a response straight to decode when the buffer is empty.
module instr_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [63:0] RESET_PC        = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc_E,
    input  logic [63:0] PCTarget_E,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [63:0] ImemReqAddr,
    input  logic        ImemRespValid,
    input  logic [31:0] ImemRespData,
    output logic        InstrValid_F,
    input  logic        InstrReady_D,
    output logic [63:0] PC_F,
    output logic [31:0] Instr_F
);

    localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int FCW = $clog2(DEPTH + 1);
    localparam int TCW = $clog2(MAX_OUTSTANDING + 1);

    logic [63:0]   fetch_pc_reg;
    logic [OW-1:0] outstanding_reg;
    logic [OW-1:0] drop_cnt_reg;

    logic          req_fire;
    logic          resp_fire;
    logic          keep;
    logic          entry_push;
    logic          entry_pop;
    logic          entry_full;
    logic          entry_empty;
    logic [FCW-1:0] occupancy;
    fetch_entry_t  fifo_head;
    fetch_entry_t  head;
    fetch_entry_t  resp_entry;
    logic [63:0]   tag_pc;
    logic          tag_full;
    logic          tag_empty;
    logic [TCW-1:0] tag_count;
    logic          unused;

    // Credit check counts in-flight requests so every response is guaranteed a slot.
    assign ImemReqValid = !rst && !PCSrc_E
                        && (int'(outstanding_reg) < MAX_OUTSTANDING)
                        && (int'(occupancy) + int'(outstanding_reg) < DEPTH);
    assign ImemReqAddr  = fetch_pc_reg;
    assign req_fire     = ImemReqValid && ImemReqReady;
    assign resp_fire    = ImemRespValid && (outstanding_reg != '0);
    assign keep         = resp_fire && (drop_cnt_reg == '0) && !PCSrc_E;
    assign resp_entry   = '{pc: tag_pc, instr: ImemRespData};
    assign entry_pop    = !entry_empty && InstrReady_D && !PCSrc_E;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;
    assign bypass       = keep && entry_empty;
    assign entry_push   = keep && !(bypass && InstrReady_D);
    assign head         = entry_empty ? resp_entry : fifo_head;
    assign InstrValid_F = !entry_empty || bypass;
`else
    assign entry_push   = keep;
    assign head         = fifo_head;
    assign InstrValid_F = !entry_empty;
`endif

    assign PC_F    = InstrValid_F ? head.pc    : 64'h0;
    assign Instr_F = InstrValid_F ? head.instr : 32'h0;
    assign unused  = ^{tag_full, tag_empty, tag_count, entry_full, PCTarget_E[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= align_pc(RESET_PC);
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
        end else if (PCSrc_E) begin
            // Everything still in flight belongs to the squashed path.
            fetch_pc_reg    <= align_pc(PCTarget_E);
            outstanding_reg <= outstanding_reg - OW'(resp_fire);
            drop_cnt_reg    <= outstanding_reg - OW'(resp_fire);
        end else begin
            if (req_fire) fetch_pc_reg <= fetch_pc_reg + 64'(INSTR_BYTES);
            outstanding_reg <= outstanding_reg + OW'(req_fire) - OW'(resp_fire);
            if (resp_fire && (drop_cnt_reg != '0)) drop_cnt_reg <= drop_cnt_reg - 1'b1;
        end
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (entry_push),
        .pop   (entry_pop),
        .flush (PCSrc_E),
        .din   (resp_entry),
        .dout  (fifo_head),
        .full  (entry_full),
        .empty (entry_empty),
        .count (occupancy)
    );

    // Tags of dropped responses vanish with the flush, so only kept responses pop.
    sync_fifo #(.WIDTH(64), .DEPTH(MAX_OUTSTANDING)) tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (keep),
        .flush (PCSrc_E),
        .din   (fetch_pc_reg),
        .dout  (tag_pc),
        .full  (tag_full),
        .empty (tag_empty),
        .count (tag_count)
    );

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench: stimulus queues expected PCs, a negedge monitor checks each delivery.
module tb_instr_prefetch_queue;

    localparam int MAXO = 2;
`ifdef PREFETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrc_E = 1'b0;
    logic [63:0] PCTarget_E = '0;
    logic        ImemReqValid;
    logic        ImemReqReady = 1'b0;
    logic [63:0] ImemReqAddr;
    logic        ImemRespValid = 1'b0;
    logic [31:0] ImemRespData = '0;
    logic        InstrValid_F;
    logic        InstrReady_D = 1'b0;
    logic [63:0] PC_F;
    logic [31:0] Instr_F;

    always #5 clk = ~clk;

    instr_prefetch_queue dut (
        .clk           (clk),
        .rst           (rst),
        .PCSrc_E       (PCSrc_E),
        .PCTarget_E    (PCTarget_E),
        .ImemReqValid  (ImemReqValid),
        .ImemReqReady  (ImemReqReady),
        .ImemReqAddr   (ImemReqAddr),
        .ImemRespValid (ImemRespValid),
        .ImemRespData  (ImemRespData),
        .InstrValid_F  (InstrValid_F),
        .InstrReady_D  (InstrReady_D),
        .PC_F          (PC_F),
        .Instr_F       (Instr_F)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [63:0] exp_q[$];
    logic [63:0] exp_next = 64'h0;
    logic [63:0] model_fetch = 64'h0;
    int tests = 0, fails = 0, cyc = 0, delivered = 0, first_cyc = -1;
    int last_due = 0, lat_fixed = 1, lat_rand = 0, rdy_pct = 100, dec_pct = 100;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted head must match the next expected PC.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && !PCSrc_E) begin
            if (InstrValid_F && InstrReady_D) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL deliver: got pc %0h with nothing expected", PC_F);
                end else begin
                    e = exp_q.pop_front();
                    chk("deliver_pc", PC_F, e);
                    chk("deliver_instr", {32'h0, Instr_F}, {32'h0, instr_of(e)});
                    $display("[TB] cycle %0d deliver pc=%0h instr=%0h", cyc, PC_F, Instr_F);
                end
                delivered++;
                if (first_cyc < 0) first_cyc = cyc;
            end else if (!InstrValid_F) begin
                chk("idle_pc_zero", PC_F, 64'h0);
                chk("idle_instr_zero", {32'h0, Instr_F}, 64'h0);
            end
        end
    end

    // One clock: model imem at negedge, then drive new inputs just after posedge.
    task automatic step();
        int lat, due;
        @(negedge clk);
        if (rst) begin
            pend.delete();
            model_fetch = 64'h0;
            last_due = 0;
        end else begin
            if (ImemRespValid) pend.delete(0);
            if (ImemReqValid && ImemReqReady) begin
                chk("req_addr", ImemReqAddr, model_fetch);
                lat = (lat_rand != 0) ? int'($urandom_range(1, 5)) : lat_fixed;
                due = cyc + lat;
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend.push_back('{ImemReqAddr, due});
                model_fetch += 64'd4;
            end
            if (PCSrc_E) model_fetch = {PCTarget_E[63:2], 2'b00};
            chk("outstanding_le_max", 64'(pend.size() > MAXO), 64'h0);
        end
        @(posedge clk);
        #1;
        cyc++;
        ImemRespValid = 1'b0;
        if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
            ImemRespValid = 1'b1;
            ImemRespData  = instr_of(pend[0].addr);
        end
        ImemReqReady = ($urandom_range(0, 99) < rdy_pct);
        InstrReady_D = ($urandom_range(0, 99) < dec_pct);
        while (exp_q.size() < 8) begin
            exp_q.push_back(exp_next);
            exp_next += 64'd4;
        end
    endtask

    task automatic redirect(input logic [63:0] tgt);
        PCSrc_E    = 1'b1;
        PCTarget_E = tgt;
        exp_q.delete();
        exp_next   = {tgt[63:2], 2'b00};
        $display("[TB] cycle %0d redirect to %0h", cyc, tgt);
        step();
        PCSrc_E = 1'b0;
    endtask

    initial begin
        int rel, d0;
        logic [63:0] tgt;

        // Reset state
        repeat (3) step();
        #1;
        chk("rst_req_valid", 64'(ImemReqValid), 64'h0);
        chk("rst_instr_valid", 64'(InstrValid_F), 64'h0);
        chk("rst_pc_f", PC_F, 64'h0);
        chk("rst_instr_f", {32'h0, Instr_F}, 64'h0);
        chk("rst_req_addr", ImemReqAddr, 64'h0);

        // Streaming with zero-wait imem
        rst = 1'b0;
        ImemReqReady = 1'b1;
        InstrReady_D = 1'b1;
        rel = cyc;
        repeat (30) step();
        #1;
        chk("first_latency", 64'(first_cyc - rel), 64'(LAT));
        chk("stream_count", 64'(delivered), 64'(30 - LAT));

        // Decode stall: buffer fills, requests stop, nothing lost
        dec_pct = 0;
        InstrReady_D = 1'b0;
        d0 = delivered;
        repeat (20) step();
        #1;
        chk("stall_no_deliver", 64'(delivered - d0), 64'h0);
        chk("stall_req_valid", 64'(ImemReqValid), 64'h0);
        chk("stall_head_valid", 64'(InstrValid_F), 64'h1);
        chk("stall_drained_imem", 64'(pend.size()), 64'h0);
        rdy_pct = 0;
        ImemReqReady = 1'b0;
        dec_pct = 100;
        InstrReady_D = 1'b1;
        d0 = delivered;
        repeat (6) step();
        chk("full_occupancy", 64'(delivered - d0), 64'd4);
        rdy_pct = 100;
        ImemReqReady = 1'b1;
        repeat (10) step();

        // Redirect with two requests in flight
        lat_fixed = 4;
        repeat (6) step();
        for (int i = 0; i < 20 && pend.size() != 2; i++) step();
        chk("two_outstanding", 64'(pend.size()), 64'd2);
        redirect(64'h100);
        #1;
        chk("empty_after_redirect", 64'(InstrValid_F), 64'h0);
        lat_fixed = 1;
        d0 = delivered;
        repeat (12) step();
        chk("redirect_progress", 64'(delivered > d0), 64'h1);

        // Redirect coinciding with a response
        lat_fixed = 2;
        repeat (10) step();
        for (int i = 0; i < 20 && !(ImemRespValid && pend.size() == 2); i++) step();
        chk("resp_in_redirect_cycle", 64'(ImemRespValid && pend.size() == 2), 64'h1);
        redirect(64'h100);
        d0 = delivered;
        repeat (12) step();
        chk("redirect2_progress", 64'(delivered > d0), 64'h1);

        // Misaligned target
        redirect(64'h203);
        #1;
        chk("aligned_addr", ImemReqAddr, 64'h200);
        repeat (8) step();

        // Random latency, back-pressure and redirects
        lat_rand = 1;
        rdy_pct = 70;
        dec_pct = 70;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                tgt = 64'($urandom_range(0, 32'hFFFF));
                redirect(tgt);
            end else begin
                step();
            end
        end

        // Quiesce and confirm everything drained
        lat_rand = 0;
        rdy_pct = 0;
        dec_pct = 100;
        repeat (40) step();
        #1;
        chk("final_imem_idle", 64'(pend.size()), 64'h0);
        chk("final_empty", 64'(InstrValid_F), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
